// File: rtl/player_move_ctrl.sv
// -----------------------------------------------------------------------------
// player_move_ctrl
//
// Purpose
//   Moves the player one tile through the maze for each direction request.
//   The target map row is fetched over the map-ROM port, which is shared with
//   the VGA renderer through a req/gnt handshake. The wall bit for the target
//   column is then tested, and the move is either committed or reported as
//   blocked. After a committed move a cooldown limits the step rate, so a held
//   button gives evenly spaced steps.
//
// Parameters
//   START_COL    reset column of the player tile (0..MAP_WIDTH-1)
//   START_ROW    reset row of the player tile    (0..MAP_HEIGHT-1)
//   STEP_CYCLES  cooldown cycles after a committed move (0 = no cooldown)
//   CNT_W        cooldown counter width, >= clog2(STEP_CYCLES+1)
//   MAP_WIDTH    maze width in tiles  (row word width)
//   MAP_HEIGHT   maze height in tiles
//
// Ports
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   dir_valid   in   direction request strobe, sampled only while idle
//   dir         in   00=UP(row-1) 01=DOWN(row+1) 10=LEFT(col-1) 11=RIGHT(col+1)
//   map_req     out  request for the shared map-ROM port
//   map_addr    out  row address to the ROM, valid while map_req=1
//   map_gnt     in   grant; the ROM latches map_addr when map_req & map_gnt
//   map_data    in   row word, valid the cycle after the grant;
//                    bit MAP_WIDTH-1-col holds tile col (1 = wall)
//   player_col  out  current tile column
//   player_row  out  current tile row
//   moved       out  1-cycle pulse: move committed
//   blocked     out  1-cycle pulse: move rejected (wall or off the map)
//   busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module player_move_ctrl #(
  parameter int START_COL   = 1,
  parameter int START_ROW   = 8,
  parameter int STEP_CYCLES = 2500000,
  parameter int CNT_W       = 22,
  parameter int MAP_WIDTH   = 20,
  parameter int MAP_HEIGHT  = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 dir_valid,
  input  logic [1:0]           dir,
  output logic                 map_req,
  output logic [3:0]           map_addr,
  input  logic                 map_gnt,
  input  logic [MAP_WIDTH-1:0] map_data,
  output logic [4:0]           player_col,
  output logic [3:0]           player_row,
  output logic                 moved,
  output logic                 blocked,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_COOL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Target arithmetic runs 7 bits wide and signed, so a step off either edge
  // shows up as a negative or too-large value instead of wrapping.
  localparam logic signed [6:0] MAP_W_S  = 7'(MAP_WIDTH);
  localparam logic signed [6:0] MAP_H_S  = 7'(MAP_HEIGHT);
  localparam logic [CNT_W-1:0]  STEP_CNT = CNT_W'(STEP_CYCLES);

  state_e           state_q, state_d;
  logic [4:0]       col_q, col_d;
  logic [3:0]       row_q, row_d;
  logic [4:0]       tcol_q, tcol_d;
  logic [3:0]       trow_q, trow_d;
  logic             moved_q, moved_d;
  logic             blocked_q, blocked_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [6:0]    tcol_s, trow_s;
  logic                 off_map;
  logic [MAP_WIDTH-1:0] row_by_col;
  logic                 wall_hit;

  // ---------------------------------------------------------------------------
  // Target tile for the requested direction, computed from the live position.
  // ---------------------------------------------------------------------------
  always_comb begin
    tcol_s = $signed({2'b00, col_q});
    trow_s = $signed({3'b000, row_q});
    unique case (dir_e'(dir))
      DIR_UP:    trow_s = trow_s - 7'sd1;
      DIR_DOWN:  trow_s = trow_s + 7'sd1;
      DIR_LEFT:  tcol_s = tcol_s - 7'sd1;
      DIR_RIGHT: tcol_s = tcol_s + 7'sd1;
      default:   ;
    endcase
    off_map = (tcol_s < 7'sd0) || (tcol_s >= MAP_W_S) ||
              (trow_s < 7'sd0) || (trow_s >= MAP_H_S);
  end

  // The ROM stores column 0 in the MSB. Reversing the word lets the wall bit
  // be picked directly by column number.
  always_comb begin
    for (int i = 0; i < MAP_WIDTH; i++) begin
      row_by_col[i] = map_data[MAP_WIDTH-1-i];
    end
  end

  assign wall_hit = row_by_col[tcol_q];

  // ---------------------------------------------------------------------------
  // State register (also holds position, latched target, pulses and counter)
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with <= so all of them update
  // together from values settled before the edge; using = would let later
  // lines see earlier updates from the same edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      col_q     <= 5'(START_COL);
      row_q     <= 4'(START_ROW);
      tcol_q    <= '0;
      trow_q    <= '0;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      tcol_q    <= tcol_d;
      trow_q    <= trow_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
      cnt_q     <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a hold/idle default before the case statement.
  // A path that missed an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    tcol_d    = tcol_q;
    trow_d    = trow_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (dir_valid) begin
          if (off_map) begin
            // Rejected without touching the ROM. The request is not answered
            // while the previous result pulse is still high, so moved/blocked
            // never sit high on two back-to-back cycles. A held button simply
            // retries on the next cycle.
            blocked_d = !(moved_q || blocked_q);
          end else begin
            tcol_d  = tcol_s[4:0];
            trow_d  = trow_s[3:0];
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // The address comes from trow_q, so it stays stable while the
        // renderer holds the port.
        if (map_gnt) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (wall_hit) begin
          blocked_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          col_d   = tcol_q;
          row_d   = trow_q;
          moved_d = 1'b1;
          state_d = (STEP_CYCLES == 0) ? S_IDLE : S_COOL;
        end
      end

      S_COOL: begin
        // The first COOL cycle overlaps the moved pulse. STEP_CYCLES more
        // cycles follow before IDLE, so a held button steps every
        // 3 + STEP_CYCLES + 1 cycles.
        if (cnt_q == STEP_CNT) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. map_req and busy decode the state directly, so an asynchronous
  // reset drops them at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    map_req    = (state_q == S_REQ);
    busy       = (state_q != S_IDLE);
    map_addr   = trow_q;
    player_col = col_q;
    player_row = row_q;
    moved      = moved_q;
    blocked    = blocked_q;
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_move_ctrl
//
// Directed bench for player_move_ctrl.
//
// u_dut   starts at (1,8) with a 4-cycle cooldown. It covers the main move path,
//         walls, grant stalls, reset mid-operation and a held button.
// u_dut0  starts at (1,0) with no cooldown. It covers the off-map case and
//         the zero-cooldown path.
//
// A small ROM model answers both units: it latches the row on req & gnt and
// returns the data on the following cycle.
// -----------------------------------------------------------------------------
module tb_player_move_ctrl;

  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] DOWN  = 2'b01;
  localparam logic [1:0] LEFT  = 2'b10;
  localparam logic [1:0] RIGHT = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        dir_valid, map_gnt;
  logic [1:0]  dir;
  logic        map_req, moved, blocked, busy;
  logic [3:0]  map_addr, player_row;
  logic [4:0]  player_col;
  logic [19:0] map_data;

  logic        dir_valid_0, map_gnt_0;
  logic [1:0]  dir_0;
  logic        map_req_0, moved_0, blocked_0, busy_0;
  logic [3:0]  map_addr_0, player_row_0;
  logic [4:0]  player_col_0;
  logic [19:0] map_data_0;

  player_move_ctrl #(
    .START_COL(1), .START_ROW(8), .STEP_CYCLES(4), .CNT_W(4),
    .MAP_WIDTH(20), .MAP_HEIGHT(10)
  ) u_dut (
    .clk(clk), .resetn(resetn), .dir_valid(dir_valid), .dir(dir),
    .map_req(map_req), .map_addr(map_addr), .map_gnt(map_gnt),
    .map_data(map_data), .player_col(player_col), .player_row(player_row),
    .moved(moved), .blocked(blocked), .busy(busy)
  );

  player_move_ctrl #(
    .START_COL(1), .START_ROW(0), .STEP_CYCLES(0), .CNT_W(1),
    .MAP_WIDTH(20), .MAP_HEIGHT(10)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .dir_valid(dir_valid_0), .dir(dir_0),
    .map_req(map_req_0), .map_addr(map_addr_0), .map_gnt(map_gnt_0),
    .map_data(map_data_0), .player_col(player_col_0),
    .player_row(player_row_0), .moved(moved_0), .blocked(blocked_0),
    .busy(busy_0)
  );

  // ROM model: bit 19 is column 0, 1 = wall.
  logic [19:0] rom [0:15];
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[7] = 20'b10111111001000101001;
    rom[8] = 20'b10000000001111100001;
  end

  always @(posedge clk) begin
    if (map_req && map_gnt)     map_data   <= rom[map_addr];
    if (map_req_0 && map_gnt_0) map_data_0 <= rom[map_addr_0];
  end

  // Checking
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitors on the main unit
  int   n_moved = 0, n_blocked = 0, bad_seq = 0, req0_seen = 0;
  logic prev_pulse = 1'b0;
  logic mon_req0 = 1'b1;

  always @(negedge clk) begin
    if (moved)   n_moved++;
    if (blocked) n_blocked++;
    if ((moved && blocked) || ((moved || blocked) && prev_pulse)) bad_seq++;
    prev_pulse = moved || blocked;
    if (mon_req0 && map_req_0) req0_seen++;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus helpers. All of them start and end on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic send(input logic [1:0] d);
    dir       = d;
    dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  // Called one falling edge after the accepting rising edge.
  // lat counts falling edges up to and including the first one where moved
  // or blocked is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!(moved || blocked) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 1'b0);
  endtask

  int lat, base;
  int t_mv [3];
  int n_mv;

  initial begin
    resetn = 1'b0; dir_valid = 1'b0; dir = UP; map_gnt = 1'b1;
    dir_valid_0 = 1'b0; dir_0 = UP; map_gnt_0 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_col",   player_col, 5'd1);
    check("rst_row",   player_row, 4'd8);
    check("rst_req",   map_req, 1'b0);
    check("rst_addr",  map_addr, 4'd0);
    check("rst_moved", moved, 1'b0);
    check("rst_blk",   blocked, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst0_row",  player_row_0, 4'd0);
    resetn = 1'b1;
    @(negedge clk);

    // T1: RIGHT into free tile, immediate grant, 4-cycle cooldown
    send(RIGHT);
    check("t1_req",  map_req, 1'b1);
    check("t1_addr", map_addr, 4'd8);
    check("t1_busy", busy, 1'b1);
    @(negedge clk);
    check("t1_req_drop", map_req, 1'b0);
    @(negedge clk);
    check("t1_moved", moved, 1'b1);
    check("t1_col",   player_col, 5'd2);
    check("t1_row",   player_row, 4'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_cool_busy", busy, 1'b1);
    end
    @(negedge clk);
    check("t1_idle", busy, 1'b0);

    // T2a: UP into free tile of row 7
    do_reset();
    send(UP);
    wait_result(lat);
    check("t2a_lat",   lat, 3);
    check("t2a_moved", moved, 1'b1);
    check("t2a_blk",   blocked, 1'b0);
    check("t2a_col",   player_col, 5'd1);
    check("t2a_row",   player_row, 4'd7);
    wait_idle("t2a_idle");

    // T2b: LEFT into wall at column 0
    do_reset();
    send(LEFT);
    wait_result(lat);
    check("t2b_lat",   lat, 3);
    check("t2b_blk",   blocked, 1'b1);
    check("t2b_moved", moved, 1'b0);
    check("t2b_col",   player_col, 5'd1);
    check("t2b_row",   player_row, 4'd8);
    check("t2b_busy",  busy, 1'b0);
    @(negedge clk);
    check("t2b_blk_pulse", blocked, 1'b0);

    // T3: UP from row 0 is off the map; the ROM is never requested
    dir_0 = UP; dir_valid_0 = 1'b1;
    @(negedge clk);
    dir_valid_0 = 1'b0;
    check("t3_blk",  blocked_0, 1'b1);
    check("t3_busy", busy_0, 1'b0);
    @(negedge clk);
    check("t3_blk_pulse", blocked_0, 1'b0);
    check("t3_row",       player_row_0, 4'd0);
    check("t3_noreq",     req0_seen, 0);
    mon_req0 = 1'b0;
    // Zero-cooldown unit: DOWN commits and returns straight to IDLE
    dir_0 = DOWN; dir_valid_0 = 1'b1;
    @(negedge clk);
    dir_valid_0 = 1'b0;
    check("t3b_req", map_req_0, 1'b1);
    repeat (2) @(negedge clk);
    check("t3b_moved", moved_0, 1'b1);
    check("t3b_row",   player_row_0, 4'd1);
    check("t3b_busy",  busy_0, 1'b0);

    // T4: grant withheld; request held stable; requests while busy ignored
    do_reset();
    base = n_moved;
    map_gnt = 1'b0;
    send(UP);
    check("t4_req",  map_req, 1'b1);
    check("t4_addr", map_addr, 4'd7);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      check("t4_req_hold",  map_req, 1'b1);
      check("t4_addr_hold", map_addr, 4'd7);
      if (i == 3) begin dir = DOWN; dir_valid = 1'b1; end
      if (i == 4) dir_valid = 1'b0;
      if (i == 6) map_gnt = 1'b1;
    end
    @(negedge clk);
    check("t4_req_drop", map_req, 1'b0);
    @(negedge clk);
    check("t4_moved", moved, 1'b1);
    check("t4_row",   player_row, 4'd7);
    wait_idle("t4_idle");
    #1;
    check("t4_one_move", n_moved - base, 1);
    check("t4_row_end",  player_row, 4'd7);

    // T5a: reset while in REQ
    do_reset();
    map_gnt = 1'b0;
    send(UP);
    @(negedge clk);
    check("t5a_req", map_req, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("t5a_req_rst", map_req, 1'b0);
    check("t5a_busy",    busy, 1'b0);
    check("t5a_col",     player_col, 5'd1);
    check("t5a_row",     player_row, 4'd8);
    base = n_moved + n_blocked;
    @(negedge clk);
    map_gnt = 1'b1;
    resetn  = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("t5a_no_pulse", n_moved + n_blocked - base, 0);
    check("t5a_idle",     busy, 1'b0);

    // T5b: reset while in COOL
    @(negedge clk);
    send(RIGHT);
    wait_result(lat);
    check("t5b_moved", moved, 1'b1);
    check("t5b_col",   player_col, 5'd2);
    @(negedge clk);
    check("t5b_cool", busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    check("t5b_col_rst", player_col, 5'd1);
    check("t5b_row_rst", player_row, 4'd8);
    check("t5b_busy",    busy, 1'b0);
    check("t5b_req",     map_req, 1'b0);
    base = n_moved + n_blocked;
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("t5b_no_pulse", n_moved + n_blocked - base, 0);
    check("t5b_idle",     busy, 1'b0);

    // T6: held RIGHT along row 8 -> moves every 3+4+1 = 8 cycles
    @(negedge clk);
    n_mv = 0;
    dir = RIGHT;
    dir_valid = 1'b1;
    for (int k = 0; k < 60 && n_mv < 3; k++) begin
      @(negedge clk);
      if (moved) begin
        t_mv[n_mv] = cyc;
        n_mv++;
      end
    end
    dir_valid = 1'b0;
    check("t6_moves", n_mv, 3);
    check("t6_gap1", (n_mv >= 2) ? t_mv[1] - t_mv[0] : -1, 8);
    check("t6_gap2", (n_mv >= 3) ? t_mv[2] - t_mv[1] : -1, 8);
    wait_idle("t6_idle");
    check("t6_col", player_col, 5'd4);
    check("t6_row", player_row, 4'd8);

    check("pulse_excl", bad_seq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
